// File: rtl/al4s3b_wb_decode_mux_pkg.sv
// Shared types and constants for the Wishbone FPGA-aperture decode/mux.
// State encodings, region-select width, default reserved base and stats width.
package al4s3b_wb_decode_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int         REGION_W      = 2;
  localparam logic [9:0] RSVD_BASE_DEF = 10'h07E;
  localparam int         STAT_CNT_W    = 16;

endpackage

// File: rtl/al4s3b_wb_decode_mux_if.sv
// Master-side Wishbone bus between the AHB-to-FPGA bridge and the decode mux.
// master = bridge view, slave = decode-mux view.
interface al4s3b_wb_decode_mux_if #(
  parameter int ADDRWIDTH = 10,
  parameter int DATAWIDTH = 32
);
  logic [ADDRWIDTH-1:0] WBm_ADR;
  logic                 WBm_CYC;
  logic                 WBm_STB;
  logic                 WBm_WE;
  logic [DATAWIDTH-1:0] WBm_DAT;
  logic                 WBm_ACK;

  modport master (
    output WBm_ADR, WBm_CYC, WBm_STB, WBm_WE,
    input  WBm_DAT, WBm_ACK
  );

  modport slave (
    input  WBm_ADR, WBm_CYC, WBm_STB, WBm_WE,
    output WBm_DAT, WBm_ACK
  );
endinterface

// File: rtl/al4s3b_wb_addr_decode.sv
// Combinational word-address decode: one-hot user slave, reserved pair, or unmapped.
// Reserved pair match overrides the region decode; regions >= NUM_SLV are unmapped.
module al4s3b_wb_addr_decode
  import al4s3b_wb_decode_mux_pkg::*;
#(
  parameter int                   ADDRWIDTH = 10,
  parameter int                   NUM_SLV   = 3,
  parameter logic [ADDRWIDTH-1:0] RSVD_BASE = ADDRWIDTH'(RSVD_BASE_DEF)
) (
  input  logic [ADDRWIDTH-1:0] adr_i,
  output logic [NUM_SLV-1:0]   slv_sel_o,
  output logic                 rsvd_sel_o,
  output logic                 unmapped_o
);

  logic [REGION_W-1:0] region;
  logic                unused_adr;

  assign region     = adr_i[ADDRWIDTH-1 -: REGION_W];
  assign rsvd_sel_o = (adr_i[ADDRWIDTH-1:1] == RSVD_BASE[ADDRWIDTH-1:1]);
  // Bit 0 only distinguishes the two reserved words, which share one select.
  assign unused_adr = adr_i[0];

  always_comb begin
    slv_sel_o = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      slv_sel_o[k] = !rsvd_sel_o && (region == REGION_W'(k));
    end
  end

  assign unmapped_o = !rsvd_sel_o && !(|slv_sel_o);

endmodule

// File: rtl/al4s3b_wb_decode_mux.sv
// Wishbone decode, slave select and registered ACK/data return; one transfer in flight, ack 1 cycle after slave ack.
// Optional unmapped-access statistics built only with WB_DECODE_STATS_EN defined.
module al4s3b_wb_decode_mux
  import al4s3b_wb_decode_mux_pkg::*;
#(
  parameter int                   ADDRWIDTH = 10,
  parameter int                   DATAWIDTH = 32,
  parameter int                   NUM_SLV   = 3,
  parameter logic [ADDRWIDTH-1:0] RSVD_BASE = ADDRWIDTH'(RSVD_BASE_DEF)
) (
  input  logic                           WBs_CLK_i,
  input  logic                           WBs_RSTn_i,
  al4s3b_wb_decode_mux_if.slave          wbm,
  output logic [ADDRWIDTH-1:0]           WBs_ADR_o,
  output logic                           WBs_WE_o,
  output logic                           WBs_STB_o,
  output logic [NUM_SLV-1:0]             WBs_CYC_o,
  output logic                           WBs_CYC_QL_Reserved_o,
  output logic                           WBs_CYC_Any_o,
  input  logic [NUM_SLV-1:0]             WBs_ACK_slv_i,
  input  logic [NUM_SLV*DATAWIDTH-1:0]   WBs_DAT_slv_i,
  input  logic                           WBs_ACK_QL_Reserved_i,
  input  logic [DATAWIDTH-1:0]           WBs_DAT_QL_Reserved_i,
  output logic                           WBs_ACK_Any_o,
  output logic [STAT_CNT_W-1:0]          Unmapped_Cnt_o,
  output logic [ADDRWIDTH-1:0]           Unmapped_Adr_o
);

  logic [NUM_SLV-1:0]   dec_slv;
  logic                 dec_rsvd;
  logic                 dec_unmapped;

  state_e               state_q;
  logic [ADDRWIDTH-1:0] adr_q;
  logic                 we_q;
  logic                 stb_q;
  logic [NUM_SLV-1:0]   cyc_q;
  logic                 cyc_rsvd_q;
  logic                 cyc_any_q;
  logic [DATAWIDTH-1:0] dat_q;
  logic                 ack_q;

  logic                 req;
  logic [NUM_SLV-1:0]   user_ack;
  logic [DATAWIDTH-1:0] user_dat;
  logic                 done;

  al4s3b_wb_addr_decode #(
    .ADDRWIDTH (ADDRWIDTH),
    .NUM_SLV   (NUM_SLV),
    .RSVD_BASE (RSVD_BASE)
  ) u_addr_decode (
    .adr_i      (wbm.WBm_ADR),
    .slv_sel_o  (dec_slv),
    .rsvd_sel_o (dec_rsvd),
    .unmapped_o (dec_unmapped)
  );

  assign req      = wbm.WBm_CYC & wbm.WBm_STB;
  // Only the selected slave's ack counts; strays from other slaves are masked.
  assign user_ack = WBs_ACK_slv_i & cyc_q;
  assign done     = !wbm.WBm_CYC || (|user_ack) || WBs_ACK_QL_Reserved_i;

  always_comb begin
    user_dat = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (cyc_q[k]) user_dat = WBs_DAT_slv_i[k*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      stb_q      <= 1'b0;
      cyc_q      <= '0;
      cyc_rsvd_q <= 1'b0;
      cyc_any_q  <= 1'b0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            adr_q      <= wbm.WBm_ADR;
            we_q       <= wbm.WBm_WE;
            stb_q      <= 1'b1;
            cyc_q      <= dec_slv;
            cyc_rsvd_q <= dec_rsvd;
            cyc_any_q  <= 1'b1;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Abort (CYC low) wins over a same-cycle ack and returns nothing.
          if (done) begin
            stb_q      <= 1'b0;
            cyc_q      <= '0;
            cyc_rsvd_q <= 1'b0;
            cyc_any_q  <= 1'b0;
            ack_q      <= wbm.WBm_CYC;
            state_q    <= wbm.WBm_CYC ? ST_RESP : ST_IDLE;
            if (wbm.WBm_CYC) dat_q <= (|user_ack) ? user_dat : WBs_DAT_QL_Reserved_i;
          end
        end
        ST_RESP: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbm.WBm_DAT           = dat_q;
  assign wbm.WBm_ACK           = ack_q;
  assign WBs_ADR_o             = adr_q;
  assign WBs_WE_o              = we_q;
  assign WBs_STB_o             = stb_q;
  assign WBs_CYC_o             = cyc_q;
  assign WBs_CYC_QL_Reserved_o = cyc_rsvd_q;
  assign WBs_CYC_Any_o         = cyc_any_q;
  assign WBs_ACK_Any_o         = |WBs_ACK_slv_i;

`ifdef WB_DECODE_STATS_EN
  logic [STAT_CNT_W-1:0] ucnt_q;
  logic [ADDRWIDTH-1:0]  uadr_q;

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      ucnt_q <= '0;
      uadr_q <= '0;
    end else if (state_q == ST_IDLE && req && dec_unmapped) begin
      if (ucnt_q != '1) ucnt_q <= ucnt_q + STAT_CNT_W'(1);
      uadr_q <= wbm.WBm_ADR;
    end
  end

  assign Unmapped_Cnt_o = ucnt_q;
  assign Unmapped_Adr_o = uadr_q;
`else
  logic unused_stats;
  assign unused_stats   = dec_unmapped;
  assign Unmapped_Cnt_o = '0;
  assign Unmapped_Adr_o = '0;
`endif

endmodule

// File: tb/tb_al4s3b_wb_decode_mux.sv
// Directed bench for al4s3b_wb_decode_mux: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_al4s3b_wb_decode_mux;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   s_adr;
  logic            s_we, s_stb, s_any, s_cyc_rsvd, ack_any;
  logic [NS-1:0]   s_cyc;
  logic [NS-1:0]   ack_slv = '0;
  logic [NS*DW-1:0] dat_slv = '0;
  logic            ack_rsvd = 1'b0;
  logic [DW-1:0]   dat_rsvd = '0;
  logic [15:0]     ucnt;
  logic [AW-1:0]   uadr;

  int total = 0;
  int bad   = 0;

  al4s3b_wb_decode_mux_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) wbm ();

  al4s3b_wb_decode_mux #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_SLV(NS)) dut (
    .WBs_CLK_i             (clk),
    .WBs_RSTn_i            (rst_n),
    .wbm                   (wbm),
    .WBs_ADR_o             (s_adr),
    .WBs_WE_o              (s_we),
    .WBs_STB_o             (s_stb),
    .WBs_CYC_o             (s_cyc),
    .WBs_CYC_QL_Reserved_o (s_cyc_rsvd),
    .WBs_CYC_Any_o         (s_any),
    .WBs_ACK_slv_i         (ack_slv),
    .WBs_DAT_slv_i         (dat_slv),
    .WBs_ACK_QL_Reserved_i (ack_rsvd),
    .WBs_DAT_QL_Reserved_i (dat_rsvd),
    .WBs_ACK_Any_o         (ack_any),
    .Unmapped_Cnt_o        (ucnt),
    .Unmapped_Adr_o        (uadr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one transfer in flight, response the cycle after the winning ack.
  bit          m_busy = 0, m_rsvd = 0, m_ack = 0, m_resp = 0, m_we = 0, m_ack_we = 0;
  logic [2:0]  m_sel = '0;
  logic [9:0]  m_adr = '0;
  logic [31:0] m_dat = '0;
  int          m_ucnt = 0;
  logic [9:0]  m_uadr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_rsvd = 0; m_ack = 0; m_resp = 0; m_sel = '0;
      m_dat = '0; m_ucnt = 0; m_uadr = '0;
    end else begin
      automatic bit was_resp = m_resp;
      automatic int region;
      m_ack = 0;
      m_resp = 0;
      if (m_busy) begin
        if (!wbm.WBm_CYC) begin
          m_busy = 0; m_sel = '0; m_rsvd = 0;
        end else if ((m_sel & ack_slv) != 0 || ack_rsvd) begin
          if ((m_sel & ack_slv) != 0) begin
            for (int i = 0; i < NS; i++) if (m_sel[i]) m_dat = dat_slv[i*DW +: DW];
          end else begin
            m_dat = dat_rsvd;
          end
          m_busy = 0; m_sel = '0; m_rsvd = 0;
          m_ack = 1; m_resp = 1; m_ack_we = m_we;
        end
      end else if (!was_resp && wbm.WBm_CYC && wbm.WBm_STB) begin
        region = int'(wbm.WBm_ADR) / 256;
        m_busy = 1;
        m_adr  = wbm.WBm_ADR;
        m_we   = wbm.WBm_WE;
        m_rsvd = (int'(wbm.WBm_ADR) / 2) == (126 / 2);
        m_sel  = (!m_rsvd && region < NS) ? 3'(1 << region) : 3'b000;
        if (!m_rsvd && m_sel == 0) begin
          m_ucnt = (m_ucnt < 65535) ? m_ucnt + 1 : m_ucnt;
          m_uadr = wbm.WBm_ADR;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ack", wbm.WBm_ACK, m_ack);
    if (m_ack && !m_ack_we) chk("m_dat", wbm.WBm_DAT, m_dat);
    chk("m_cyc", s_cyc, m_sel);
    chk("m_cyc_rsvd", s_cyc_rsvd, m_rsvd);
    chk("m_cyc_any", s_any, m_busy);
    chk("m_stb", s_stb, m_busy);
    if (m_busy) begin
      chk("m_adr", s_adr, m_adr);
      chk("m_we", s_we, m_we);
    end
    chk("m_ack_any", ack_any, |ack_slv);
`ifdef WB_DECODE_STATS_EN
    chk("m_ucnt", ucnt, 16'(m_ucnt));
    chk("m_uadr", uadr, m_uadr);
`else
    chk("m_ucnt", ucnt, 16'h0);
    chk("m_uadr", uadr, 10'h0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [9:0] a, input logic we);
    wbm.WBm_ADR = a; wbm.WBm_WE = we; wbm.WBm_CYC = 1'b1; wbm.WBm_STB = 1'b1;
  endtask

  task automatic idle_master();
    wbm.WBm_CYC = 1'b0; wbm.WBm_STB = 1'b0; wbm.WBm_WE = 1'b0;
  endtask

  initial begin
    wbm.WBm_ADR = '0;
    idle_master();
    repeat (3) tick();
    chk("rst_ack", wbm.WBm_ACK, 1'b0);
    chk("rst_dat", wbm.WBm_DAT, 32'h0);
    chk("rst_adr", s_adr, 10'h0);
    chk("rst_cyc", s_cyc, 3'b000);
    chk("rst_any", s_any, 1'b0);
    chk("rst_ucnt", ucnt, 16'h0);
    rst_n = 1'b1;
    tick();

    // Reserved ID word
    req(10'h07E, 1'b0); tick();
    chk("rsvd_sel", s_cyc_rsvd, 1'b1);
    chk("rsvd_cyc", s_cyc, 3'b000);
    tick();
    ack_rsvd = 1'b1; dat_rsvd = 32'h0000_0100; tick();
    ack_rsvd = 1'b0; dat_rsvd = '0;
    chk("rsvd_ack", wbm.WBm_ACK, 1'b1);
    chk("rsvd_dat", wbm.WBm_DAT, 32'h0000_0100);
    idle_master(); tick();
    chk("rsvd_ack_pulse", wbm.WBm_ACK, 1'b0);

    // Slave 1 with wait states and a stray ack from slave 0
    req(10'h105, 1'b0); tick();
    chk("s1_cyc", s_cyc, 3'b010);
    chk("s1_adr", s_adr, 10'h105);
    ack_slv = 3'b001; dat_slv = {32'h0, 32'h0, 32'hBAD0_0000}; tick();
    ack_slv = 3'b000; tick(); tick();
    chk("s1_stray_ignored", wbm.WBm_ACK, 1'b0);
    ack_slv = 3'b010; dat_slv = {32'h0, 32'hA5A5_0001, 32'h0}; tick();
    ack_slv = 3'b000;
    chk("s1_ack", wbm.WBm_ACK, 1'b1);
    chk("s1_dat", wbm.WBm_DAT, 32'hA5A5_0001);
    idle_master(); tick();
    chk("s1_ack_pulse", wbm.WBm_ACK, 1'b0);

    // Unmapped region 3: reserved block times out
    req(10'h3F0, 1'b0); tick();
    chk("um_cyc", s_cyc, 3'b000);
    chk("um_rsvd", s_cyc_rsvd, 1'b0);
    chk("um_any", s_any, 1'b1);
    repeat (6) tick();
    chk("um_no_early_ack", wbm.WBm_ACK, 1'b0);
    ack_rsvd = 1'b1; dat_rsvd = 32'hDEFF_ABAC; tick();
    ack_rsvd = 1'b0;
    chk("um_ack", wbm.WBm_ACK, 1'b1);
    chk("um_dat", wbm.WBm_DAT, 32'hDEFF_ABAC);
`ifdef WB_DECODE_STATS_EN
    chk("um_cnt", ucnt, 16'h0001);
    chk("um_adr", uadr, 10'h3F0);
`else
    chk("um_cnt", ucnt, 16'h0000);
    chk("um_adr", uadr, 10'h000);
`endif
    idle_master(); tick();

    // Slave 0 and reserved ack together: slave wins
    req(10'h010, 1'b0); tick();
    chk("s0_cyc", s_cyc, 3'b001);
    ack_slv = 3'b001; dat_slv = {32'h0, 32'h0, 32'h1111_0000};
    ack_rsvd = 1'b1; dat_rsvd = 32'hDEFF_ABAC; tick();
    ack_slv = 3'b000; ack_rsvd = 1'b0;
    chk("race_ack", wbm.WBm_ACK, 1'b1);
    chk("race_dat", wbm.WBm_DAT, 32'h1111_0000);
    idle_master(); tick();
    chk("race_single_pulse", wbm.WBm_ACK, 1'b0);
    tick();
    chk("race_no_second", wbm.WBm_ACK, 1'b0);

    // Write to slave 2
    req(10'h2AA, 1'b1); tick();
    chk("wr_cyc", s_cyc, 3'b100);
    chk("wr_we", s_we, 1'b1);
    ack_slv = 3'b100; dat_slv = {32'h2222_0002, 64'h0}; tick();
    ack_slv = 3'b000;
    chk("wr_ack", wbm.WBm_ACK, 1'b1);
    idle_master(); tick();

    // Abort during BUSY, then a late ack
    req(10'h205, 1'b0); tick();
    chk("ab_cyc", s_cyc, 3'b100);
    idle_master(); tick();
    chk("ab_cyc_clr", s_cyc, 3'b000);
    chk("ab_any_clr", s_any, 1'b0);
    ack_slv = 3'b100; tick();
    ack_slv = 3'b000;
    chk("ab_no_ack", wbm.WBm_ACK, 1'b0);
    tick();
    chk("ab_no_ack2", wbm.WBm_ACK, 1'b0);

    // Reset mid-BUSY
    req(10'h105, 1'b0); tick();
    chk("rb_cyc", s_cyc, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_cyc0", s_cyc, 3'b000);
    chk("rb_any0", s_any, 1'b0);
    chk("rb_stb0", s_stb, 1'b0);
    chk("rb_adr0", s_adr, 10'h0);
    chk("rb_dat0", wbm.WBm_DAT, 32'h0);
    chk("rb_ack0", wbm.WBm_ACK, 1'b0);
    chk("rb_ucnt0", ucnt, 16'h0);
    idle_master();
    #2 rst_n = 1'b1;
    tick();
    req(10'h07F, 1'b0); tick();
    chk("rb_next_rsvd", s_cyc_rsvd, 1'b1);
    ack_rsvd = 1'b1; dat_rsvd = 32'h0000_0200; tick();
    ack_rsvd = 1'b0;
    chk("rb_next_ack", wbm.WBm_ACK, 1'b1);
    chk("rb_next_dat", wbm.WBm_DAT, 32'h0000_0200);
    idle_master(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/al4s3b_wb_decode_mux.md
# al4s3b_wb_decode_mux

Wishbone address decoder, slave-select generator and read-data/acknowledge return mux for the FPGA memory aperture. It sits between the AHB-to-FPGA bridge (master side) and the FPGA IPs, including the QL-reserved ID/default-acknowledge block. It registers one transfer at a time, drives exactly one slave chip-select, and merges the returned ACK/data into a single registered response. It also produces the "any IP acknowledged" signal that the reserved block's timeout logic consumes.

## Interface
- ADDRWIDTH, 10, word-address width.
- DATAWIDTH, 32, data width.
- NUM_SLV, 3, user IP slaves (1..4); slave k owns region ADR[ADDRWIDTH-1:ADDRWIDTH-2]==k.
- RSVD_BASE, 10'h07E, first of two reserved words; ADR[ADDRWIDTH-1:1]==RSVD_BASE[ADDRWIDTH-1:1] selects reserved block, overriding region decode.
- WBs_CLK_i  in  1  Wishbone FPGA clock.
- WBs_RSTn_i  in  1  asynchronous, active-low reset.
- WBm_ADR_i  in  ADDRWIDTH  master address.
- WBm_CYC_i, WBm_STB_i, WBm_WE_i  in  1 each  master cycle, strobe, write enable.
- WBm_DAT_o  out  DATAWIDTH  registered read data.
- WBm_ACK_o  out  1  registered acknowledge, one-cycle pulse.
- WBs_ADR_o  out  ADDRWIDTH  latched address to all slaves.
- WBs_WE_o, WBs_STB_o  out  1 each  latched write enable, strobe.
- WBs_CYC_o  out  NUM_SLV  one-hot user-slave select.
- WBs_CYC_QL_Reserved_o  out  1  reserved-block select.
- WBs_CYC_Any_o  out  1  high while any transfer is in flight (reserved block's CYC_i).
- WBs_ACK_slv_i  in  NUM_SLV  user-slave acknowledges.
- WBs_DAT_slv_i  in  NUM_SLV*DATAWIDTH  user-slave read data, slave k at [k*DATAWIDTH +: DATAWIDTH].
- WBs_ACK_QL_Reserved_i  in  1  reserved-block ack (ID hit or default timeout).
- WBs_DAT_QL_Reserved_i  in  DATAWIDTH  reserved-block read data.
- WBs_ACK_Any_o  out  1  combinational OR of WBs_ACK_slv_i (reserved block's WBs_ACK_i).
- Unmapped_Cnt_o  out  16  unmapped-access count (see Configuration).
- Unmapped_Adr_o  out  ADDRWIDTH  last unmapped address.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: on WBm_CYC_i&WBm_STB_i latch ADR/WE, compute select, go BUSY. Select = reserved if RSVD match; else slave k if region k<NUM_SLV; else unmapped (no select bit set, WBs_CYC_Any_o still high so the reserved timeout fires).
- BUSY: hold WBs_*_o stable. Accept ack from the selected slave, or WBs_ACK_QL_Reserved_i (always accepted: covers reserved hits and default timeout). Capture that source's data into WBm_DAT_o, pulse WBm_ACK_o, drop all selects, go RESP.
- Same-cycle user ack and reserved ack: user slave wins, its data returned.
- Acks from non-selected user slaves ignored.
- RESP: one cycle; return to IDLE. A new request is not accepted in RESP (bridge deasserts STB after ack).
- Abort: WBm_CYC_i low in BUSY -> IDLE next edge, selects cleared, no WBm_ACK_o, late acks ignored.
- Writes: identical flow; WBm_DAT_o is loaded but don't-care.

## Timing
- Reset: state IDLE; all outputs 0 (WBm_DAT_o, WBs_ADR_o, counters included).
- Request sampled at edge 0 -> selects high after edge 0.
- Slave ack high in cycle n -> WBm_ACK_o/WBm_DAT_o valid after edge n+1 for exactly one cycle.
- Minimum request-to-ack: 2 cycles for a zero-wait slave.
- Unmapped: reserved timeout (7 cycles) then +1 cycle.
- Reset mid-BUSY: immediate return to reset values; no ack is generated.

## Configuration
- WB_DECODE_STATS_EN defined: each unmapped request entering BUSY increments Unmapped_Cnt_o, saturating at 16'hFFFF, and loads Unmapped_Adr_o with the address.
- Not defined: both outputs tied to 0 and no counter logic is built.

## Structure
- Shared package: state encodings (IDLE=0, BUSY=1, RESP=2), region-select width (2), default RSVD_BASE, stats counter width (16).
- One sub-module, al4s3b_wb_addr_decode: combinational address -> one-hot/reserved/unmapped select, instantiated once.

## Test plan
- Read ADR=10'h07E -> WBs_CYC_QL_Reserved_o=1; reserved acks with 32'h0000_0100 -> WBm_DAT_o=32'h0000_0100, single-cycle ack.
- Read ADR=10'h105, slave 1 acks after 3 cycles with 32'hA5A5_0001 -> WBs_CYC_o=3'b010; WBm_ACK_o one cycle after slave ack.
- Read ADR=10'h3F0 with NUM_SLV=3 -> no select bits; reserved timeout data 32'hDEFFABAC returned; Unmapped_Cnt_o=1 and Unmapped_Adr_o=10'h3F0 with macro, 0 without.
- Slave 0 and reserved ack in the same cycle -> slave 0 data returned, one ack pulse.
- WBm_CYC_i dropped during BUSY, then slave ack arrives -> no WBm_ACK_o, state IDLE.
- WBs_RSTn_i asserted during BUSY -> all outputs 0 at once; next request decodes normally.
